// File: rtl/reg_file_loader.sv
// Byte-stream loader for the program/constant register file: packs DW/8 bytes
// MSB-first into one word and writes it at auto-incrementing addresses.
module reg_file_loader #(
    parameter int AW = 8,
    parameter int DW = 48
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [AW:0]   word_count_i,
    input  logic [7:0]    byte_in_i,
    input  logic          byte_valid_i,
    output logic          byte_ready_o,
    output logic [AW-1:0] write_addr_o,
    output logic [DW-1:0] write_data_o,
    output logic          write_en_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int            BPW       = DW / 8;
    localparam int            CW        = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);
    localparam logic [AW:0]   ONE_WORD  = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_e;

    state_e        state_q,      state_d;
    logic [AW-1:0] addr_q,       addr_d;
    logic [AW:0]   remaining_q,  remaining_d;
    logic [CW-1:0] byte_cnt_q,   byte_cnt_d;
    logic [DW-1:0] assembly_q,   assembly_d;
    logic [AW-1:0] write_addr_q, write_addr_d;
    logic [DW-1:0] write_data_q, write_data_d;

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        byte_cnt_d   = byte_cnt_q;
        assembly_d   = assembly_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        byte_ready_o = 1'b0;
        write_en_o   = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d      = base_addr_i;
                    remaining_d = word_count_i;
                    state_d     = (word_count_i == '0) ? DONE : COLLECT;
                end
            end

            COLLECT: begin
                busy_o       = 1'b1;
                byte_ready_o = 1'b1;
                if (byte_valid_i) begin
                    assembly_d = (assembly_q << 8) | DW'(byte_in_i);
                    if (byte_cnt_q == LAST_BYTE) begin
                        // Output registers load here so they hold steady
                        // outside WRITE, with write_en_o as the only qualifier.
                        byte_cnt_d   = '0;
                        write_addr_d = addr_q;
                        write_data_d = assembly_d;
                        state_d      = WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end

            WRITE: begin
                busy_o      = 1'b1;
                write_en_o  = 1'b1;
                addr_d      = addr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                state_d     = (remaining_q == ONE_WORD) ? DONE : COLLECT;
            end

            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            byte_cnt_q   <= '0;
            assembly_q   <= '0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            byte_cnt_q   <= byte_cnt_d;
            assembly_q   <= assembly_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign write_addr_o = write_addr_q;
    assign write_data_o = write_data_q;

    // Write strobe and completion pulse are exclusive single-cycle events.
    assert property (@(posedge clk_i) disable iff (reset_i) !(write_en_o && done_o));
    assert property (@(posedge clk_i) disable iff (reset_i) write_en_o |=> !write_en_o);

endmodule

// File: tb/tb_reg_file_loader.sv
// Scoreboard bench for reg_file_loader: expected writes are queued as loads
// are driven and retired by a monitor when write_en_o fires.
module tb_reg_file_loader;

    localparam int AW  = 8;
    localparam int DW  = 48;
    localparam int BPW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready_o;
    logic [AW-1:0] write_addr_o;
    logic [DW-1:0] write_data_o;
    logic          write_en_o;
    logic          busy_o;
    logic          done_o;

    reg_file_loader #(.AW(AW), .DW(DW)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .word_count_i (word_count),
        .byte_in_i    (byte_in),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready_o),
        .write_addr_o (write_addr_o),
        .write_data_o (write_data_o),
        .write_en_o   (write_en_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  we_cycles[$];
    int  compared    = 0;
    int  mismatched  = 0;
    int  cyc         = 0;
    int  last_we_cyc = -100;
    int  done_count  = 0;
    bit  zero_load   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t e;
        if (!reset && write_en_o) begin
            check("we_ready", byte_ready_o, 0);
            check("we_busy", busy_o, 1);
            check("we_done", done_o, 0);
            check("we_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("we_addr", write_addr_o, e.addr);
                check("we_data", write_data_o, e.data);
            end
            last_we_cyc = cyc;
            we_cycles.push_back(cyc);
        end
        if (!reset && done_o) begin
            done_count++;
            check("done_busy", busy_o, 0);
            check("done_ready", byte_ready_o, 0);
            if (!zero_load) check("done_latency", cyc - last_we_cyc, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] cnt);
        start      = 1'b1;
        base_addr  = base;
        word_count = cnt;
        tick();
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        repeat (gap) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready_o) ok = 1'b1;
            tick();
        end
        byte_valid = 1'b0;
        check("byte_accepted", ok, 1);
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int max_gap);
        for (int i = 0; i < BPW; i++)
            send_byte(w[DW-1-8*i -: 8], int'($urandom_range(0, max_gap)));
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic settle(input string tag);
        repeat (3) tick();
        @(negedge clk);
        check({tag, "_idle_busy"}, busy_o, 0);
        check({tag, "_drained"}, exp_q.size(), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] words[3];
        logic [AW-1:0] a;
        int            dc;
        int            wc;

        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        byte_in = '0; byte_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_write_addr", write_addr_o, 0);
        check("rst_write_data", write_data_o, 0);
        check("rst_write_en", write_en_o, 0);
        check("rst_ready", byte_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        tick();
        reset = 1'b0;
        tick();

        // Single word, back-to-back bytes.
        expect_write(8'h10, 48'h010203040506);
        do_start(8'h10, 9'd1);
        send_word(48'h010203040506, 0);
        settle("t1");

        // Three words across the address wrap, continuous stream.
        words[0] = 48'h111213141516;
        words[1] = 48'h212223242526;
        words[2] = 48'h313233343536;
        we_cycles.delete();
        a = 8'hFE;
        for (int i = 0; i < 3; i++) begin
            expect_write(a, words[i]);
            a = a + 1'b1;
        end
        do_start(8'hFE, 9'd3);
        for (int i = 0; i < 3; i++) send_word(words[i], 0);
        settle("t2");
        check("t2_write_count", we_cycles.size(), 3);
        if (we_cycles.size() == 3) begin
            check("t2_spacing_1", we_cycles[1] - we_cycles[0], 7);
            check("t2_spacing_2", we_cycles[2] - we_cycles[1], 7);
        end

        // Two words with random stalls between bytes.
        expect_write(8'h50, 48'hDEADBEEFCAFE);
        expect_write(8'h51, 48'h0123456789AB);
        do_start(8'h50, 9'd2);
        send_word(48'hDEADBEEFCAFE, 5);
        send_word(48'h0123456789AB, 5);
        settle("t3");

        // Zero-count load, plus a Start held during the DONE cycle.
        zero_load = 1'b1;
        wc = we_cycles.size();
        dc = done_count;
        start = 1'b1; base_addr = 8'h33; word_count = '0;
        @(negedge clk);
        check("t4_done_before", done_o, 0);
        tick();
        start = 1'b1; base_addr = 8'h77; word_count = 9'd5;
        @(negedge clk);
        check("t4_done_pulse", done_o, 1);
        check("t4_ready", byte_ready_o, 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("t4_done_after", done_o, 0);
        check("t4_start_in_done_ignored", busy_o, 0);
        check("t4_ready_after", byte_ready_o, 0);
        tick();
        check("t4_no_writes", we_cycles.size(), wc);
        check("t4_one_done", done_count, dc + 1);
        zero_load = 1'b0;
        settle("t4");

        // Start during COLLECT is ignored.
        expect_write(8'h40, 48'hA1A2A3A4A5A6);
        expect_write(8'h41, 48'hB1B2B3B4B5B6);
        do_start(8'h40, 9'd2);
        send_byte(8'hA1, 0);
        send_byte(8'hA2, 0);
        send_byte(8'hA3, 0);
        do_start(8'h80, 9'd1);
        send_byte(8'hA4, 0);
        send_byte(8'hA5, 0);
        send_byte(8'hA6, 0);
        send_word(48'hB1B2B3B4B5B6, 0);
        settle("t5");

        // Reset after three bytes discards the partial word.
        wc = we_cycles.size();
        do_start(8'h20, 9'd1);
        send_byte(8'h99, 0);
        send_byte(8'h98, 0);
        send_byte(8'h97, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_ready", byte_ready_o, 0);
        check("t6_rst_addr", write_addr_o, 0);
        check("t6_rst_data", write_data_o, 0);
        tick();
        repeat (8) tick();
        check("t6_no_partial_write", we_cycles.size(), wc);
        expect_write(8'h21, 48'hAABBCCDDEEFF);
        do_start(8'h21, 9'd1);
        send_word(48'hAABBCCDDEEFF, 0);
        settle("t6");

        check("final_pending", exp_q.size(), 0);
        check("done_total", done_count, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reg_file_loader.md
Name: reg_file_loader

Overview:
- Write-side companion to the read-only 48-bit program/constant register file.
- Accepts a byte stream over a valid/ready handshake and assembles dw/8 bytes per word, MSB first.
- Issues one single-cycle write per assembled word into the register file's write port, at auto-incrementing addresses from a programmed base.
- Sits between the boot/debug byte source and the register file; used to preload contents before the core runs.

Parameters:
aw, 8, address bus width of the target register file
dw, 48, word width; must be a multiple of 8; BPW = dw/8 bytes per word (6 by default)
size, 1<<aw, number of register file entries; address arithmetic wraps modulo size

Ports:
Clock  input  1  single clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  begin a load; sampled only in IDLE
Base_Addr  input  aw  first write address, latched on accepted Start
Word_Count  input  aw+1  number of words to load (0..size), latched on accepted Start
Byte_In  input  8  stream data byte
Byte_Valid  input  1  Byte_In is valid
Byte_Ready  output  1  loader accepts a byte this cycle
Write_Addr  output  aw  register file write address
Write_Data  output  dw  register file write data
Write_En  output  1  register file write strobe, one cycle per word
Busy  output  1  load in progress
Done  output  1  one-cycle pulse at load completion

Behaviour:
- Reset (synchronous, active-high): state IDLE. Byte_Ready=0, Write_En=0, Busy=0, Done=0, Write_Addr=0, Write_Data=0. Byte counter, remaining-word count and assembly register are cleared.
- Reset mid-load: the partial word is discarded and no write is issued. Reset has priority over every other input.
- States are IDLE, COLLECT, WRITE and DONE.
- IDLE:
  - Busy=0, Byte_Ready=0.
  - Start=1 latches Base_Addr into the address register and Word_Count into the remaining count.
  - If Word_Count==0, go to DONE (no writes). Otherwise go to COLLECT.
- COLLECT:
  - Busy=1, Byte_Ready=1.
  - A byte is accepted when Byte_Valid && Byte_Ready. On acceptance: assembly <= {assembly[dw-9:0], Byte_In}, byte_cnt++.
  - The first byte of a word lands in bits [dw-1:dw-8].
  - Byte_Valid=0 is a stall with no state change. No limit on stall length.
  - Acceptance of byte BPW-1 goes to WRITE next cycle, with byte_cnt cleared to 0.
- WRITE (exactly one cycle):
  - Write_En=1, Write_Addr=current address, Write_Data=assembled word. Byte_Ready=0, Busy=1.
  - Next cycle: address <= address+1 (mod size, so 255+1 wraps to 0) and remaining <= remaining-1.
  - If remaining was 1, go to DONE. Otherwise go to COLLECT.
- DONE (one cycle): Done=1, Busy=0, Byte_Ready=0, then IDLE.
- Output timing:
  - Write_En and Done are high only in WRITE and DONE respectively. They are never high in the same cycle.
  - Write_Addr and Write_Data hold their last values outside WRITE. Write_En is the only qualifier.
- Start while not in IDLE is ignored, including in DONE.
- Latency:
  - Minimum BPW+1 cycles per word (6 accepts + 1 write).
  - Done is asserted the cycle after the final Write_En.
  - A zero-count Start gives Done the cycle after Start.
- Word_Count==size loads every entry once, wrapping from base.

Test Plan:
- Reset, then Start with Base_Addr=0x10, Word_Count=1, bytes 01 02 03 04 05 06 back-to-back -> one Write_En cycle with addr 0x10, data 0x010203040506. Done pulses the next cycle, then Busy=0.
- Word_Count=3 from base 0xFE, 18 continuous bytes -> writes at 0xFE, 0xFF, 0x00, each 7 cycles apart. Byte_Ready is low during each WRITE cycle.
- Byte_Valid toggled randomly with gaps of 0–5 cycles, 2 words -> data identical to the gap-free run. No byte is lost or duplicated.
- Start with Word_Count=0 -> no Write_En; Done is high exactly one cycle after Start. Byte_Ready stays 0.
- Start pulsed again during COLLECT with different Base_Addr -> ignored; writes continue at the original addresses.
- Reset asserted after 3 of 6 bytes -> no Write_En. A new Start with count 1 and bytes AA..FF -> data 0xAABBCCDDEEFF, proving the partial word was discarded.
